int_to_fp: RTL and testbench

//  Pipelined 32-bit integer -> IEEE-754 single-precision converter (1s/8e/23m).

---
 rtl/fp_pkg.sv | 18 +
 rtl/int_to_fp_lzc32.sv | 15 +
 rtl/int_to_fp.sv | 87 ++++++++
 tb/tb_int_to_fp.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the integer->FP converter and the FP adder.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam int    FP_BIAS      = 127;
    localparam int    ITOF_EXP_TOP = FP_BIAS + 31;

    localparam fp32_t FP_POS_INF = fp32_t'(32'h7F80_0000);
    localparam fp32_t FP_NEG_INF = fp32_t'(32'hFF80_0000);
    localparam fp32_t FP_POS_MAX = fp32_t'(32'h7F7F_FFFF);
    localparam fp32_t FP_NEG_MIN = fp32_t'(32'hFF7F_FFFF);

endpackage

// File: rtl/int_to_fp_lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
    input  logic [31:0] i_val,
    output logic [5:0]  o_lz
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        o_lz = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i_val[i]) o_lz = 6'(31 - i);
        end
    end

endmodule

// File: rtl/int_to_fp.sv
// 3-stage int32 -> FP32 converter with valid/ready handshake and a global stall.
// Build option: define ITOF_RNE_EN for round-to-nearest-even, otherwise truncation.
module int_to_fp
    import fp_pkg::*;
#(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [31:0] in_data,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [31:0] out_data,
    output logic        busy
);

`ifdef ITOF_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        w_en;
    logic [3:1]  r_vld;

    logic        w_s1_sign;
    logic [31:0] w_s1_mag;
    logic        r_s1_sign;
    logic [31:0] r_s1_mag;

    logic [5:0]  w_lz;
    logic [31:0] w_norm;
    logic        r_s2_sign;
    logic [4:0]  r_s2_lz;
    logic [31:0] r_s2_norm;

    logic [7:0]  w_exp;
    logic        w_rnd;
    logic [30:0] w_em;
    fp32_t       r_out;

    assign w_en     = out_rdy | ~r_vld[3];
    assign in_rdy   = w_en;
    assign out_vld  = r_vld[3];
    assign busy     = |r_vld;
    assign out_data = r_out;

    // Two's-complement negate in 32 bits is exact: 0x8000_0000 maps to 2^31.
    assign w_s1_sign = SIGNED_IN & in_data[31];
    assign w_s1_mag  = w_s1_sign ? (~in_data + 32'd1) : in_data;

    lzc32 u_lzc (
        .i_val (r_s1_mag),
        .o_lz  (w_lz)
    );

    assign w_norm = r_s1_mag << w_lz;

    // Rounding carry out of the mantissa ripples straight into the exponent.
    assign w_exp = 8'(ITOF_EXP_TOP) - {3'b000, r_s2_lz};
    assign w_rnd = RNE & r_s2_norm[7] & ((|r_s2_norm[6:0]) | r_s2_norm[8]);
    assign w_em  = {w_exp, r_s2_norm[30:8]} + {30'd0, w_rnd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_s1_sign <= 1'b0;
            r_s1_mag  <= '0;
            r_s2_sign <= 1'b0;
            r_s2_lz   <= '0;
            r_s2_norm <= '0;
            r_out     <= '0;
        end else if (w_en) begin
            r_vld     <= {r_vld[2:1], in_vld};
            r_s1_sign <= w_s1_sign;
            r_s1_mag  <= w_s1_mag;
            r_s2_sign <= r_s1_sign;
            r_s2_lz   <= w_lz[4:0];
            r_s2_norm <= w_norm;
            // A clear hidden bit means the magnitude was zero: emit +0, never -0.
            r_out     <= r_s2_norm[31] ? fp32_t'({r_s2_sign, w_em}) : '0;
        end
    end

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench: signed and unsigned converters side by side, checked
// against an arithmetic FP32 reference model and hand-derived constants.
module tb_int_to_fp;

`ifdef ITOF_RNE_EN
    localparam bit          RNE    = 1'b1;
    localparam logic [31:0] E_0103 = 32'h4B80_0002;
    localparam logic [31:0] E_FFFF = 32'h4F80_0000;
`else
    localparam bit          RNE    = 1'b0;
    localparam logic [31:0] E_0103 = 32'h4B80_0001;
    localparam logic [31:0] E_FFFF = 32'h4F7F_FFFF;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        out_rdy = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_rdy_s, in_rdy_u, out_vld_s, out_vld_u, busy_s, busy_u;
    logic [31:0] out_s, out_u;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_out = 0;
    logic [31:0] q_s[$];
    logic [31:0] q_u[$];

    always #5 clk = ~clk;

    int_to_fp #(.SIGNED_IN(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy_s), .in_data(in_data),
        .out_vld(out_vld_s), .out_rdy(out_rdy), .out_data(out_s), .busy(busy_s)
    );

    int_to_fp #(.SIGNED_IN(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy_u), .in_data(in_data),
        .out_vld(out_vld_u), .out_rdy(out_rdy), .out_data(out_u), .busy(busy_u)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: locate the top bit, scale to a 24-bit significand, then round.
    function automatic logic [31:0] ref_fp(input logic [31:0] d, input bit sgn);
        longint m, q, rem, half;
        int     e, sh;
        bit     neg;
        neg = sgn && d[31];
        m   = neg ? -longint'($signed(d)) : longint'(d);
        if (m == 0) return 32'h0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            sh  = e - 23;
            q   = m >> sh;
            rem = m - (q << sh);
            if (RNE) begin
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && q[0])) q++;
                if (q == (longint'(1) << 24)) begin
                    q = q >> 1;
                    e++;
                end
            end
        end
        return {neg, 8'(e + 127), q[22:0]};
    endfunction

    // Scoreboard: handshakes sampled at negedge take effect on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_s.delete();
            q_u.delete();
        end else begin
            if (out_vld_s && out_rdy) begin
                n_out++;
                chk("sb_occupied", 32'(q_s.size() != 0), 32'd1);
                chk("out_vld_u", {31'd0, out_vld_u}, 32'd1);
                if (q_s.size() != 0) begin
                    chk("sb_signed", out_s, q_s.pop_front());
                    chk("sb_unsigned", out_u, q_u.pop_front());
                end
            end
            if (in_vld && in_rdy_s) begin
                q_s.push_back(ref_fp(in_data, 1'b1));
                q_u.push_back(ref_fp(in_data, 1'b0));
            end
        end
    end

    task automatic send(input logic [31:0] d);
        bit ok;
        int t;
        in_vld  = 1'b1;
        in_data = d;
        ok = 1'b0;
        t  = 0;
        do begin
            @(negedge clk);
            ok = in_rdy_s;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 50);
        chk("send_accept", {31'd0, ok}, 32'd1);
        in_vld = 1'b0;
    endtask

    task automatic conv(input string tag, input logic [31:0] d,
                        input logic [31:0] es, input logic [31:0] eu);
        int k;
        send(d);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_vld_s && k < 20);
        chk({tag, "_lat"}, 32'(k), 32'd3);
        chk({tag, "_s"}, out_s, es);
        chk({tag, "_u"}, out_u, eu);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int acc, n0, stall, gaps, t, vcnt;
        logic [31:0] d;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld", {31'd0, out_vld_s}, 32'd0);
        chk("rst_busy", {31'd0, busy_s}, 32'd0);
        chk("rst_out_data", out_s, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_rdy", {31'd0, in_rdy_s}, 32'd1);
        chk("rst_out_data_u", out_u, 32'h0);

        out_rdy = 1'b1;
        conv("one",   32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
        conv("neg1",  32'hFFFF_FFFF, 32'hBF80_0000, E_FFFF);
        conv("zero",  32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        conv("min",   32'h8000_0000, 32'hCF00_0000, 32'h4F00_0000);
        conv("rnd3",  32'h0100_0003, E_0103,        E_0103);
        conv("tie1",  32'h0100_0001, 32'h4B80_0000, 32'h4B80_0000);

        // Backpressure: the 3-deep pipe fills, then the head item must hold.
        out_rdy = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            in_vld  = 1'b1;
            in_data = 32'(acc + 1);
            @(negedge clk);
            t = {31'd0, in_rdy_s};
            @(posedge clk);
            #1;
            if (t != 0) acc++;
        end
        chk("bp_accepted", 32'(acc), 32'd3);
        chk("bp_in_rdy", {31'd0, in_rdy_s}, 32'd0);
        chk("bp_hold_s", out_s, 32'h3F80_0000);
        chk("bp_hold_u", out_u, 32'h3F80_0000);
        n0 = n_out;
        out_rdy = 1'b1;
        t = 0;
        while (acc < 5 && t < 50) begin
            in_vld  = 1'b1;
            in_data = 32'(acc + 1);
            @(negedge clk);
            vcnt = {31'd0, in_rdy_s};
            @(posedge clk);
            #1;
            if (vcnt != 0) acc++;
            t++;
        end
        in_vld = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_out_count", 32'(n_out - n0), 32'd5);
        chk("bp_sb_empty", 32'(q_s.size()), 32'd0);

        // Streaming: no stalls, no gaps once the pipe has filled.
        n0 = n_out;
        stall = 0;
        gaps = 0;
        for (int i = 0; i < 100; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) d = -d;
            if (i % 25 == 7) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 300));
            in_vld  = 1'b1;
            in_data = d;
            @(negedge clk);
            if (!in_rdy_s) stall++;
            if (i >= 3 && !out_vld_s) gaps++;
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stream_stalls", 32'(stall), 32'd0);
        chk("stream_gaps", 32'(gaps), 32'd0);
        chk("stream_count", 32'(n_out - n0), 32'd100);

        // Reset with two items in flight.
        send(32'h0000_0007);
        send(32'h0000_0009);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_vld", {31'd0, out_vld_s}, 32'd0);
        chk("mid_rst_busy_s", {31'd0, busy_s}, 32'd0);
        chk("mid_rst_busy_u", {31'd0, busy_u}, 32'd0);
        #20;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_vld_s || out_vld_u) vcnt++;
        end
        chk("post_rst_stale", 32'(vcnt), 32'd0);
        @(posedge clk);
        #1;
        conv("post_rst", 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
